// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FWFT FIFO controller, so the RAM wrapper
// and the controller derive address offsets and pointer widths from the same rules.
`timescale 1ns / 1ps

package ram_fifo_ctrl_pkg;

  // Per-cycle FIFO operation, encoded as {pop, push}.
  typedef enum logic [1:0] {
    OpIdle = 2'b00,
    OpPush = 2'b01,
    OpPop  = 2'b10,
    OpBoth = 2'b11
  } fifo_op_e;

  // Byte-offset LSBs of a RAM address for a word of the given width in bits.
  function automatic int unsigned addr_nc_bits(int unsigned width);
    return $clog2(width / 8);
  endfunction

  // Pointers carry one extra wrap bit above the RAM address bits.
  function automatic int unsigned ptr_width(int unsigned awidth);
    return awidth + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller that runs an external dual-port RAM (sync write, async read) as a
// first-word-fall-through FIFO between a valid/ready producer and consumer.
`timescale 1ns / 1ps

module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_AWIDTH  = 9,
  parameter int unsigned FIFO_WIDTH   = 32,
  parameter int unsigned AFULL_THRESH = 480
) (
  input  logic                                                  hclk_i,
  input  logic                                                  hreset_i,
  input  logic                                                  flush_i,
  input  logic                                                  wr_valid_i,
  output logic                                                  wr_ready_o,
  input  logic [FIFO_WIDTH-1:0]                                 wr_data_i,
  input  logic [FIFO_WIDTH/8-1:0]                               wr_strb_i,
  output logic                                                  rd_valid_o,
  input  logic                                                  rd_ready_i,
  output logic [FIFO_WIDTH-1:0]                                 rd_data_o,
  output logic [FIFO_AWIDTH:0]                                  count_o,
  output logic                                                  almost_full_o,
  output logic [FIFO_AWIDTH+addr_nc_bits(FIFO_WIDTH)-1:0]       fifo_wr_addr_o,
  output logic                                                  fifo_write_o,
  output logic [FIFO_WIDTH/8-1:0]                               fifo_wr_strb_o,
  output logic [FIFO_WIDTH-1:0]                                 fifo_wr_data_o,
  output logic [FIFO_AWIDTH+addr_nc_bits(FIFO_WIDTH)-1:0]       fifo_rd_addr_o,
  input  logic [FIFO_WIDTH-1:0]                                 fifo_rd_data_i
);

  localparam int unsigned ADDR_NC_BITS = addr_nc_bits(FIFO_WIDTH);
  localparam int unsigned PW           = ptr_width(FIFO_AWIDTH);
  localparam int unsigned RAW          = FIFO_AWIDTH + ADDR_NC_BITS;

  localparam logic [PW-1:0] PtrOne   = PW'(1);
  localparam logic [PW-1:0] AfullThr = PW'(AFULL_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;

  logic     push;
  logic     pop;
  fifo_op_e op;

  // wr_ready is gated by reset directly so nothing is written while reset is held.
  assign wr_ready_o = ~full_q & ~hreset_i;
  assign rd_valid_o = ~empty_q;

  assign push = wr_valid_i & wr_ready_o;
  assign pop  = rd_valid_o & rd_ready_i;
  assign op   = fifo_op_e'({pop, push});

  assign fifo_write_o   = push;
  assign fifo_wr_strb_o = wr_strb_i;
  assign fifo_wr_data_o = wr_data_i;
  assign fifo_wr_addr_o = RAW'(wr_ptr_q[FIFO_AWIDTH-1:0]) << ADDR_NC_BITS;
  assign fifo_rd_addr_o = RAW'(rd_ptr_q[FIFO_AWIDTH-1:0]) << ADDR_NC_BITS;

  assign rd_data_o     = fifo_rd_data_i;
  assign count_o       = count_q;
  assign almost_full_o = afull_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      // A push in the flush cycle still strobes the RAM, but the word is dropped here.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        OpPush: begin
          wr_ptr_d = wr_ptr_q + PtrOne;
          count_d  = count_q + PtrOne;
        end
        OpPop: begin
          rd_ptr_d = rd_ptr_q + PtrOne;
          count_d  = count_q - PtrOne;
        end
        OpBoth: begin
          wr_ptr_d = wr_ptr_q + PtrOne;
          rd_ptr_d = rd_ptr_q + PtrOne;
        end
        default: begin
        end
      endcase
    end

    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
              (wr_ptr_d[PW-2:0] == rd_ptr_d[PW-2:0]);
    afull_d = (count_d >= AfullThr);
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: a behavioural RAM plus a queue-based FIFO model.
`timescale 1ns / 1ps

module tb_ram_fifo_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int THR   = 6;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = 4'hF;

  logic        wr_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        almost_full;
  logic [4:0]  fifo_wr_addr;
  logic        fifo_write;
  logic [3:0]  fifo_wr_strb;
  logic [31:0] fifo_wr_data;
  logic [4:0]  fifo_rd_addr;
  logic [31:0] fifo_rd_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  int          wr_tot = 0;
  int          rd_tot = 0;

  logic [31:0] mem[DEPTH];

  ram_fifo_ctrl #(
    .FIFO_AWIDTH (AW),
    .FIFO_WIDTH  (32),
    .AFULL_THRESH(THR)
  ) dut (
    .hclk_i        (hclk),
    .hreset_i      (hreset),
    .flush_i       (flush),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_data_i     (wr_data),
    .wr_strb_i     (wr_strb),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .rd_data_o     (rd_data),
    .count_o       (count),
    .almost_full_o (almost_full),
    .fifo_wr_addr_o(fifo_wr_addr),
    .fifo_write_o  (fifo_write),
    .fifo_wr_strb_o(fifo_wr_strb),
    .fifo_wr_data_o(fifo_wr_data),
    .fifo_rd_addr_o(fifo_rd_addr),
    .fifo_rd_data_i(fifo_rd_data)
  );

  always #5 hclk = ~hclk;

  assign fifo_rd_data = mem[fifo_rd_addr[4:2]];

  always @(posedge hclk) begin
    if (fifo_write) begin
      for (int b = 0; b < 4; b++) begin
        if (fifo_wr_strb[b]) mem[fifo_wr_addr[4:2]][b*8+:8] <= fifo_wr_data[b*8+:8];
      end
    end
  end

  // Advance one clock; the model applies the FIFO rules to the inputs seen at the edge.
  task automatic tick();
    logic p, o;
    int   sz;
    @(posedge hclk);
    sz = q.size();
    p  = wr_valid && !hreset && (sz < DEPTH);
    o  = rd_ready && (sz > 0);
    if (hreset || flush) begin
      q.delete();
      wr_tot = 0;
      rd_tot = 0;
    end else begin
      if (o) begin
        void'(q.pop_front());
        rd_tot++;
      end
      if (p) begin
        q.push_back(wr_data);
        wr_tot++;
      end
    end
    @(negedge hclk);
  endtask

  task automatic test_reset();
    hreset   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL rst_fifo_write got %b exp 0", fifo_write); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull got %b exp 0", almost_full); end
    @(negedge hclk);
    hreset   = 1'b0;
    wr_valid = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rel_wr_ready got %b exp 1", wr_ready); end
    tick();
  endtask

  task automatic test_forward();
    for (int i = 0; i < 4; i++) begin
      wr_strb = 4'($urandom);
      wr_data = $urandom;
      #1;
      checks++; if (fifo_wr_strb !== wr_strb) begin errors++; $display("FAIL fwd_strb got %h exp %h", fifo_wr_strb, wr_strb); end
      checks++; if (fifo_wr_data !== wr_data) begin errors++; $display("FAIL fwd_data got %h exp %h", fifo_wr_data, wr_data); end
      tick();
    end
    wr_strb = 4'hF;
  endtask

  task automatic test_push_three();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'h11 * (i + 1);
      #1;
      checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL p3_write[%0d] got %b exp 1", i, fifo_write); end
      checks++;
      if (fifo_wr_addr !== 5'(i * 4)) begin
        errors++; $display("FAIL p3_wr_addr[%0d] got %h exp %h", i, fifo_wr_addr, 5'(i * 4));
      end
      tick();
      checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL p3_head[%0d] got %h exp 11", i, rd_data); end
    end
    wr_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL p3_count got %0d exp 3", count); end
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL p3_rd_valid got %b exp 1", rd_valid); end
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b1;
      #1;
      checks++;
      if (rd_data !== 32'h11 * (i + 1)) begin
        errors++; $display("FAIL p3_pop[%0d] got %h exp %h", i, rd_data, 32'h11 * (i + 1));
      end
      tick();
    end
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL p3_empty got %b exp 0", rd_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      #1;
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d] got %b exp 1", i, wr_ready); end
      tick();
      checks++;
      if (almost_full !== (i + 1 >= THR)) begin
        errors++; $display("FAIL full_afull[%0d] got %b exp %b", i, almost_full, (i + 1 >= THR));
      end
    end
    wr_data = 32'hBAD0_BAD0;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL full_write got %b exp 0", fifo_write); end
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
    tick();
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    #1;
    checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL full_head got %h exp %h", rd_data, q[0]); end
    tick();
    rd_ready = 1'b0;
    #1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_freed got %b exp 1", wr_ready); end
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_count7 got %0d exp 7", count); end
  endtask

  task automatic test_back_to_back();
    wr_valid = 1'b1;
    wr_data  = $urandom;
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      rd_ready = 1'b1;
      wr_data  = $urandom;
      #1;
      checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      checks++;
      if (count !== 4'(q.size())) begin
        errors++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, count, q.size());
      end
      checks++;
      if (fifo_write !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL b2b_write[%0d] got %b exp %b", i, fifo_write, (q.size() < DEPTH));
      end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      #1;
      checks++; if (rd_data !== q[0]) begin errors++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, rd_data, q[0]); end
      tick();
    end
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", rd_valid); end
  endtask

  task automatic test_empty_latency();
    wr_valid = 1'b1;
    rd_ready = 1'b1;
    wr_data  = 32'hA5A5_0001;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_before got %b exp 0", rd_valid); end
    checks++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL lat_write got %b exp 1", fifo_write); end
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", rd_valid); end
    checks++; if (rd_data !== 32'hA5A5_0001) begin errors++; $display("FAIL lat_data got %h exp a5a50001", rd_data); end
    tick();
    rd_ready = 1'b0;
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_after got %b exp 0", rd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL lat_count got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    for (int n = 5; n <= 6; n++) begin
      for (int i = 0; i < n; i++) begin
        wr_valid = 1'b1;
        wr_data  = $urandom;
        tick();
      end
      wr_valid = (n == 5);
      flush    = 1'b1;
      #1;
      checks++; if (count !== 4'(n)) begin errors++; $display("FAIL fl_count_pre%0d got %0d exp %0d", n, count, n); end
      checks++;
      if (almost_full !== (n >= THR)) begin
        errors++; $display("FAIL fl_afull_pre%0d got %b exp %b", n, almost_full, (n >= THR));
      end
      tick();
      flush    = 1'b0;
      wr_valid = 1'b0;
      #1;
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL fl_count%0d got %0d exp 0", n, count); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fl_rd_valid%0d got %b exp 0", n, rd_valid); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL fl_afull%0d got %b exp 0", n, almost_full); end
      checks++; if (fifo_wr_addr !== 5'd0) begin errors++; $display("FAIL fl_wr_addr%0d got %h exp 0", n, fifo_wr_addr); end
      checks++; if (fifo_rd_addr !== 5'd0) begin errors++; $display("FAIL fl_rd_addr%0d got %h exp 0", n, fifo_rd_addr); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      tick();
    end
    #1;
    checks++; if (count !== 4'd7) begin errors++; $display("FAIL ar_count_pre got %0d exp 7", count); end
    #1;
    hreset = 1'b1;
    #1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ar_wr_ready got %b exp 0", wr_ready); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL ar_rd_valid got %b exp 0", rd_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", count); end
    checks++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL ar_write got %b exp 0", fifo_write); end
    tick();
    hreset   = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 32'h0C0F_FEE0;
    tick();
    wr_valid = 1'b0;
    #1;
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL ar_resume_count got %0d exp 1", count); end
    checks++; if (rd_data !== 32'h0C0F_FEE0) begin errors++; $display("FAIL ar_resume_data got %h exp 0c0ffee0", rd_data); end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      rd_ready = ($urandom_range(0, 99) < 50);
      flush    = ($urandom_range(0, 99) < 3);
      wr_data  = $urandom;
      #1;
      checks++;
      if (count !== 4'(q.size())) begin
        errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, q.size());
      end
      checks++;
      if (rd_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_rd_valid[%0d] got %b exp %b", i, rd_valid, (q.size() != 0));
      end
      checks++;
      if (wr_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_wr_ready[%0d] got %b exp %b", i, wr_ready, (q.size() < DEPTH));
      end
      checks++;
      if (almost_full !== (q.size() >= THR)) begin
        errors++; $display("FAIL rnd_afull[%0d] got %b exp %b", i, almost_full, (q.size() >= THR));
      end
      checks++;
      if (fifo_write !== (wr_valid && q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_write[%0d] got %b exp %b", i, fifo_write, (wr_valid && q.size() < DEPTH));
      end
      checks++;
      if (fifo_wr_addr !== 5'((wr_tot % DEPTH) * 4)) begin
        errors++; $display("FAIL rnd_wr_addr[%0d] got %h exp %h", i, fifo_wr_addr, 5'((wr_tot % DEPTH) * 4));
      end
      checks++;
      if (fifo_rd_addr !== 5'((rd_tot % DEPTH) * 4)) begin
        errors++; $display("FAIL rnd_rd_addr[%0d] got %h exp %h", i, fifo_rd_addr, 5'((rd_tot % DEPTH) * 4));
      end
      if (q.size() != 0) begin
        checks++;
        if (rd_data !== q[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h exp %h", i, rd_data, q[0]); end
      end
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge hclk);
    test_reset();
    test_forward();
    test_push_three();
    test_full();
    test_back_to_back();
    test_empty_latency();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
